// File: rtl/oclib_width_downsizer.sv
// Serialises wide words from the upstream FIFO into narrower chunks, LSB chunk first.
// The input handshake is combinational from outReady so consecutive words stream without bubbles.

`ifndef OC_STATIC_ERROR
`define OC_STATIC_ERROR(msg) $error(msg)
`endif

module oclib_width_downsizer #(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned OutWidth = 8
) (
  input  logic                clockOut,
  input  logic                reset,
  input  logic [InWidth-1:0]  inData,
  input  logic                inValid,
  output logic                inReady,
  output logic [OutWidth-1:0] outData,
  output logic                outValid,
  input  logic                outReady,
  output logic                outLast,
  output logic                busy
);

  localparam int unsigned Ratio  = InWidth / OutWidth;
  // Guarded so an illegal Ratio still elaborates far enough to report the error.
  localparam int unsigned CountW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CountW-1:0] LastCount = CountW'(Ratio - 1);

  if ((Ratio < 2) || ((InWidth % OutWidth) != 0)) begin : gen_static_error
    `OC_STATIC_ERROR("oclib_width_downsizer: InWidth must be a multiple (>=2) of OutWidth");
  end

  logic [InWidth-1:0] hold_data_q, hold_data_d;
  logic               hold_valid_q, hold_valid_d;
  logic [CountW-1:0]  chunk_count_q, chunk_count_d;

  logic pop;
  logic last_pop;
  logic accept;

  always_comb begin
    outData  = hold_data_q[OutWidth-1:0];
    outValid = hold_valid_q;
    outLast  = hold_valid_q && (chunk_count_q == LastCount);
    busy     = hold_valid_q;
    pop      = hold_valid_q && outReady;
    last_pop = pop && outLast;
    inReady  = !reset && (!hold_valid_q || last_pop);
    accept   = inValid && inReady;
  end

  always_comb begin
    hold_data_d   = hold_data_q;
    hold_valid_d  = hold_valid_q;
    chunk_count_d = chunk_count_q;
    if (accept) begin
      // Covers a new word landing on the same edge as the previous word's last chunk.
      hold_data_d   = inData;
      hold_valid_d  = 1'b1;
      chunk_count_d = '0;
    end else if (last_pop) begin
      hold_valid_d  = 1'b0;
      chunk_count_d = '0;
    end else if (pop) begin
      hold_data_d   = hold_data_q >> OutWidth;
      chunk_count_d = chunk_count_q + 1'b1;
    end
  end

  always_ff @(posedge clockOut) begin
    if (reset) begin
      hold_data_q   <= '0;
      hold_valid_q  <= 1'b0;
      chunk_count_q <= '0;
    end else begin
      hold_data_q   <= hold_data_d;
      hold_valid_q  <= hold_valid_d;
      chunk_count_q <= chunk_count_d;
    end
  end

endmodule

// File: tb/tb_oclib_width_downsizer.sv
// Directed and randomised checks of the 32->8 width downsizer.
module tb_oclib_width_downsizer;

  logic        clockOut = 1'b0;
  logic        reset;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic        outLast;
  logic        busy;

  int errors = 0;
  int checks = 0;

  oclib_width_downsizer #(
    .InWidth (32),
    .OutWidth(8)
  ) dut (
    .clockOut(clockOut),
    .reset   (reset),
    .inData  (inData),
    .inValid (inValid),
    .inReady (inReady),
    .outData (outData),
    .outValid(outValid),
    .outReady(outReady),
    .outLast (outLast),
    .busy    (busy)
  );

  always #5 clockOut = ~clockOut;

  task automatic tick();
    @(posedge clockOut);
    #1;
  endtask

  function automatic logic [7:0] chunk_of(input logic [31:0] w, input int k);
    logic [31:0] s;
    s = w >> (8 * k);
    return s[7:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b1; inData = 32'h11223344; outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inReady !== 1'b0) begin
        errors++; $display("FAIL reset_inready cyc=%0d got=%b want=0", i, inReady);
      end
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc=%0d outValid=%b busy=%b want=0", i, outValid, busy);
      end
    end
    reset = 1'b0; inValid = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("FAIL post_reset_inready got=%b want=1", inReady);
    end
    checks++;
    if (outData !== 8'h00 || outLast !== 1'b0) begin
      errors++; $display("FAIL post_reset_out outData=%h outLast=%b want 00/0", outData, outLast);
    end
    tick();
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_consume outValid=%b busy=%b want=0", outValid, busy);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    inData = 32'hA1B2C3D4; inValid = 1'b1; outReady = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("FAIL single_idle_ready got=%b want=1", inReady);
    end
    tick();
    inValid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp[i] || outLast !== (i == 3)) begin
        errors++;
        $display("FAIL single_chunk%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, outValid, outData, outLast, exp[i], (i == 3));
      end
      checks++;
      if (inReady !== (i == 3)) begin
        errors++; $display("FAIL single_inready%0d got=%b want=%b", i, inReady, (i == 3));
      end
      tick();
    end
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL single_drain outValid=%b want=0", outValid);
    end
  endtask

  task automatic test_back_to_back();
    inData = 32'h03020100; inValid = 1'b1; outReady = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      inData  = 32'h07060504;
      inValid = (c < 4);
      #1;
      checks++;
      if (outValid !== 1'b1 || outData !== 8'(c) || outLast !== ((c % 4) == 3)) begin
        errors++;
        $display("FAIL b2b_chunk%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 c, outValid, outData, outLast, 8'(c), ((c % 4) == 3));
      end
      checks++;
      if (inReady !== ((c % 4) == 3)) begin
        errors++; $display("FAIL b2b_inready%0d got=%b want=%b", c, inReady, ((c % 4) == 3));
      end
      tick();
    end
    inValid = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain outValid=%b want=0", outValid);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int e = 0;
    int cyc = 0;
    inData = 32'h03020100; inValid = 1'b1; outReady = 1'b1;
    tick();
    while (e < 8 && cyc < 60) begin
      outReady = pat[cyc % 4];
      inValid  = (e < 4);
      inData   = 32'h07060504;
      #1;
      checks++;
      if (outValid !== 1'b1 || outData !== 8'(e) || outLast !== ((e % 4) == 3)) begin
        errors++;
        $display("FAIL bp_chunk cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 cyc, outValid, outData, outLast, 8'(e), ((e % 4) == 3));
      end
      checks++;
      if (inReady !== (((e % 4) == 3) && outReady)) begin
        errors++; $display("FAIL bp_inready cyc=%0d got=%b want=%b",
                           cyc, inReady, (((e % 4) == 3) && outReady));
      end
      if (outReady) e++;
      cyc++;
      tick();
    end
    checks++;
    if (e != 8) begin
      errors++; $display("FAIL bp_timeout chunks=%0d want=8", e);
    end
    inValid = 1'b0; outReady = 1'b1;
    #1;
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL bp_drain outValid=%b want=0", outValid);
    end
  endtask

  task automatic test_reset_mid_word();
    inData = 32'hA1B2C3D4; inValid = 1'b1; outReady = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    checks++;
    if (outData !== 8'hD4) begin
      errors++; $display("FAIL rmid_first got=%h want=d4", outData);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b0) begin
      errors++; $display("FAIL rmid_inready got=%b want=0", inReady);
    end
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0 || outData !== 8'h00) begin
        errors++; $display("FAIL rmid_discard cyc=%0d v=%b busy=%b d=%h want 0/0/00",
                           i, outValid, busy, outData);
      end
      tick();
    end
  endtask

  task automatic test_random_stream();
    localparam int NumWords = 200;
    logic [31:0] words [NumWords];
    logic [7:0]  q [$];
    int idx = 0;
    int cyc = 0;
    int popped = 0;
    int lasts = 0;
    int bad = 0;
    logic exp_ready;
    for (int i = 0; i < NumWords; i++) words[i] = $urandom;
    while ((idx < NumWords || q.size() != 0) && cyc < 20000) begin
      inValid  = (idx < NumWords) && ($urandom_range(3) != 0);
      inData   = (idx < NumWords) ? words[idx] : 32'h0;
      outReady = ($urandom_range(3) != 0);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && outReady);
      if (outValid !== (q.size() != 0) || inReady !== exp_ready ||
          (q.size() != 0 && (outData !== q[0] || outLast !== (q.size() == 1)))) begin
        bad++;
        if (bad <= 5)
          $display("FAIL rand_cycle%0d v=%b d=%h l=%b rdy=%b want v=%b d=%h l=%b rdy=%b",
                   cyc, outValid, outData, outLast, inReady, (q.size() != 0),
                   (q.size() != 0) ? q[0] : 8'h00, (q.size() == 1), exp_ready);
      end
      if (outValid === 1'b1 && outReady) begin
        popped++;
        if (outLast === 1'b1) lasts++;
      end
      if (q.size() != 0 && outReady) void'(q.pop_front());
      if (inValid && exp_ready) begin
        for (int k = 0; k < 4; k++) q.push_back(chunk_of(words[idx], k));
        idx++;
      end
      cyc++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_stream bad_cycles=%0d want=0", bad);
    end
    checks++;
    if (popped != 4 * NumWords) begin
      errors++; $display("FAIL rand_chunk_count got=%0d want=%0d", popped, 4 * NumWords);
    end
    checks++;
    if (lasts != NumWords) begin
      errors++; $display("FAIL rand_last_count got=%0d want=%0d", lasts, NumWords);
    end
    inValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
